// File: rtl/write_channel_axi.sv
// Cache write-back channel: latches one dirty line and its address, then writes
// it to memory as a single AXI4 INCR burst, replaying the burst on an error response.
module write_channel_axi #(
  parameter int FE_ADDR_W  = 32,
  parameter int FE_DATA_W  = 32,
  parameter int WORD_OFF_W = 3,
  parameter int BE_ADDR_W  = FE_ADDR_W,
  parameter int BE_DATA_W  = FE_DATA_W,
  parameter int BE_NBYTES  = BE_DATA_W / 8,
  parameter int BE_BYTE_W  = $clog2(BE_NBYTES),
  parameter int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
  parameter int LINE_W     = BE_DATA_W * (2 ** LINE2MEM_W),
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ID     = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      write_valid,
  input  logic [FE_ADDR_W-BE_BYTE_W-LINE2MEM_W-1:0] write_addr,
  input  logic [LINE_W-1:0]                         write_wdata,
  output logic                                      write_ready,
  output logic                                      axi_awvalid,
  input  logic                                      axi_awready,
  output logic [BE_ADDR_W-1:0]                      axi_awaddr,
  output logic [7:0]                                axi_awlen,
  output logic [2:0]                                axi_awsize,
  output logic [1:0]                                axi_awburst,
  output logic                                      axi_awlock,
  output logic [3:0]                                axi_awcache,
  output logic [2:0]                                axi_awprot,
  output logic [3:0]                                axi_awqos,
  output logic [AXI_ID_W-1:0]                       axi_awid,
  output logic                                      axi_wvalid,
  input  logic                                      axi_wready,
  output logic [BE_DATA_W-1:0]                      axi_wdata,
  output logic [BE_NBYTES-1:0]                      axi_wstrb,
  output logic                                      axi_wlast,
  input  logic                                      axi_bvalid,
  input  logic [1:0]                                axi_bresp,
  input  logic [AXI_ID_W-1:0]                       axi_bid,
  output logic                                      axi_bready
);

  localparam int NBEATS    = 2 ** LINE2MEM_W;
  localparam int CNT_W     = (LINE2MEM_W > 0) ? LINE2MEM_W : 1;
  localparam int ADDR_IN_W = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W;
  localparam int OFF_W     = LINE2MEM_W + BE_BYTE_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [ADDR_IN_W-1:0]               addr_q, addr_d;
  logic [NBEATS-1:0][BE_DATA_W-1:0]   line_q, line_d;
  logic write_ready_q, write_ready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic wlast_q, wlast_d;
  logic bready_q, bready_d;

  logic unused_bid;
  assign unused_bid = ^axi_bid;

  // Next-state, beat counter, line buffer and next-cycle control outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (write_valid) begin
          addr_d  = write_addr;
          line_d  = write_wdata;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (axi_awready) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (axi_wready) begin
          if (cnt_q == CNT_LAST) begin
            state_d = RESP;
          end else begin
            // a single-beat line keeps its counter pinned at zero
            cnt_d = (LINE2MEM_W > 0) ? cnt_q + CNT_W'(1) : '0;
          end
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        if (axi_bvalid) begin
          state_d = (axi_bresp == 2'b00) ? IDLE : ADDR;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    write_ready_d = (state_d == IDLE);
    awvalid_d     = (state_d == ADDR);
    wvalid_d      = (state_d == DATA);
    wlast_d       = (state_d == DATA) && (cnt_d == CNT_LAST);
    bready_d      = (state_d == RESP);
  end

  // State, datapath and registered control outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      line_q        <= '0;
      write_ready_q <= 1'b1;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      wlast_q       <= 1'b0;
      bready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      line_q        <= line_d;
      write_ready_q <= write_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      wlast_q       <= wlast_d;
      bready_q      <= bready_d;
    end
  end

  assign write_ready = write_ready_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wlast   = wlast_q;
  assign axi_bready  = bready_q;
  assign axi_wdata   = line_q[cnt_q];

  assign axi_awaddr  = BE_ADDR_W'(addr_q) << OFF_W;
  assign axi_awlen   = 8'(NBEATS - 1);
  assign axi_awsize  = 3'(BE_BYTE_W);
  assign axi_awburst = (LINE2MEM_W > 0) ? 2'b01 : 2'b00;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = 4'b0011;
  assign axi_awprot  = 3'b000;
  assign axi_awqos   = 4'b0000;
  assign axi_awid    = AXI_ID_W'(AXI_ID);
  assign axi_wstrb   = {BE_NBYTES{1'b1}};

endmodule

// File: tb/tb_write_channel_axi.sv
// Bench for write_channel_axi: an 8-beat instance under random slave timing and
// error replays, plus a single-beat instance for the degenerate burst.
module tb_write_channel_axi;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-beat instance (defaults)
  logic        a_write_valid, a_write_ready;
  logic [26:0] a_write_addr;
  logic [255:0] a_write_wdata;
  logic        a_awvalid, a_awready, a_awlock, a_wvalid, a_wready, a_wlast, a_bvalid, a_bready;
  logic [31:0] a_awaddr, a_wdata;
  logic [7:0]  a_awlen;
  logic [2:0]  a_awsize, a_awprot;
  logic [1:0]  a_awburst, a_bresp;
  logic [3:0]  a_awcache, a_awqos, a_wstrb;
  logic [0:0]  a_awid, a_bid;

  // single-beat instance
  logic        b_write_valid, b_write_ready;
  logic [29:0] b_write_addr;
  logic [31:0] b_write_wdata;
  logic        b_awvalid, b_awready, b_awlock, b_wvalid, b_wready, b_wlast, b_bvalid, b_bready;
  logic [31:0] b_awaddr, b_wdata;
  logic [7:0]  b_awlen;
  logic [2:0]  b_awsize, b_awprot;
  logic [1:0]  b_awburst, b_bresp;
  logic [3:0]  b_awcache, b_awqos, b_wstrb;
  logic [0:0]  b_awid, b_bid;

  write_channel_axi dut_a (
    .clk(clk), .reset(reset),
    .write_valid(a_write_valid), .write_addr(a_write_addr), .write_wdata(a_write_wdata),
    .write_ready(a_write_ready),
    .axi_awvalid(a_awvalid), .axi_awready(a_awready), .axi_awaddr(a_awaddr), .axi_awlen(a_awlen),
    .axi_awsize(a_awsize), .axi_awburst(a_awburst), .axi_awlock(a_awlock), .axi_awcache(a_awcache),
    .axi_awprot(a_awprot), .axi_awqos(a_awqos), .axi_awid(a_awid),
    .axi_wvalid(a_wvalid), .axi_wready(a_wready), .axi_wdata(a_wdata), .axi_wstrb(a_wstrb),
    .axi_wlast(a_wlast), .axi_bvalid(a_bvalid), .axi_bresp(a_bresp), .axi_bid(a_bid),
    .axi_bready(a_bready)
  );

  write_channel_axi #(.WORD_OFF_W(0)) dut_b (
    .clk(clk), .reset(reset),
    .write_valid(b_write_valid), .write_addr(b_write_addr), .write_wdata(b_write_wdata),
    .write_ready(b_write_ready),
    .axi_awvalid(b_awvalid), .axi_awready(b_awready), .axi_awaddr(b_awaddr), .axi_awlen(b_awlen),
    .axi_awsize(b_awsize), .axi_awburst(b_awburst), .axi_awlock(b_awlock), .axi_awcache(b_awcache),
    .axi_awprot(b_awprot), .axi_awqos(b_awqos), .axi_awid(b_awid),
    .axi_wvalid(b_wvalid), .axi_wready(b_wready), .axi_wdata(b_wdata), .axi_wstrb(b_wstrb),
    .axi_wlast(b_wlast), .axi_bvalid(b_bvalid), .axi_bresp(b_bresp), .axi_bid(b_bid),
    .axi_bready(b_bready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // mode 0: slave always ready; 1: random readies; 2: awready after 3 cycles, wready toggling
  task automatic run_burst(input logic [26:0] addr, input logic [255:0] line,
                           input int mode, input int n_err);
    logic [31:0] words [8];
    logic [31:0] exp_addr;
    int phase = 0, beat = 0, aw_n = 0, w_n = 0, errs_left = n_err;
    int cyc = 0, aw_cycles = 0, viol = 0;
    bit done = 1'b0, tog = 1'b1;
    for (int k = 0; k < 8; k++) words[k] = line[k*32 +: 32];
    exp_addr = {addr, 5'b00000};

    @(posedge clk); #1;
    a_write_valid = 1'b1; a_write_addr = addr; a_write_wdata = line;
    a_awready = 1'b0; a_wready = 1'b0; a_bvalid = 1'b0; a_bresp = 2'b00;
    @(negedge clk);
    check("ready_before_req", a_write_ready, 1);

    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      // anything presented after acceptance must be ignored
      a_write_valid = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      a_write_addr  = ~addr;
      a_write_wdata = ~line;
      case (mode)
        0: begin a_awready = 1'b1; a_wready = 1'b1; a_bvalid = 1'b1; end
        1: begin
          a_awready = 1'($urandom_range(0, 1));
          a_wready  = 1'($urandom_range(0, 1));
          a_bvalid  = 1'($urandom_range(0, 1));
        end
        default: begin a_awready = (aw_cycles >= 3); a_wready = tog; a_bvalid = 1'b1; end
      endcase
      a_bresp = (errs_left > 0) ? (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11) : 2'b00;
      tog = ~tog;
      @(negedge clk);
      if (a_wvalid && phase != 1) viol++;
      if (a_awvalid && phase != 0) viol++;
      if (a_bready && phase != 2) viol++;
      if (a_awvalid) begin
        check("awaddr_stable", a_awaddr, exp_addr);
        aw_cycles++;
      end
      if (a_awvalid && a_awready) begin
        check("aw_attrs", {a_awlen, a_awsize, a_awburst, a_awlock, a_awcache, a_awprot, a_awqos, a_awid},
              {8'd7, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0});
        if (mode == 0 && n_err == 0) check("aw_cycle", cyc, 1);
        phase = 1; beat = 0; aw_n++; aw_cycles = 0;
      end
      if (a_wvalid && a_wready) begin
        check("w_data", a_wdata, words[beat & 7]);
        check("w_last", a_wlast, (beat == 7));
        check("w_strb", a_wstrb, 4'hF);
        if (mode == 0 && n_err == 0) check("w_cycle", cyc, 2 + beat);
        beat++; w_n++;
        if (a_wlast) phase = 2;
      end
      if (a_bvalid && a_bready) begin
        if (mode == 0 && n_err == 0) check("b_cycle", cyc, 10);
        if (a_bresp != 2'b00) begin
          errs_left--; phase = 0;
        end else begin
          done = 1'b1;
        end
      end
    end
    check("burst_done", done, 1);

    @(posedge clk); #1;
    a_write_valid = 1'b0; a_awready = 1'b0; a_wready = 1'b0; a_bvalid = 1'b0; a_bresp = 2'b00;
    @(negedge clk);
    check("ready_after_b", a_write_ready, 1);
    check("idle_outputs", {a_awvalid, a_wvalid, a_wlast, a_bready}, 4'b0000);
    check("aw_count", aw_n, 1 + n_err);
    check("w_count", w_n, 8 * (1 + n_err));
    check("channel_order", viol, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] line;
    logic [26:0]  addr;

    reset = 1'b0;
    a_write_valid = 1'b0; a_write_addr = '0; a_write_wdata = '0;
    a_awready = 1'b0; a_wready = 1'b0; a_bvalid = 1'b0; a_bresp = 2'b00; a_bid = 1'b0;
    b_write_valid = 1'b0; b_write_addr = '0; b_write_wdata = '0;
    b_awready = 1'b1; b_wready = 1'b1; b_bvalid = 1'b1; b_bresp = 2'b00; b_bid = 1'b0;

    // reset held low for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_write_ready", a_write_ready, 1);
    check("rst_outputs", {a_awvalid, a_wvalid, a_wlast, a_bready}, 4'b0000);
    check("rst_b_write_ready", b_write_ready, 1);
    reset = 1'b1;

    // directed line 0x11111111..0x88888888 at byte address 0x1040
    for (int k = 0; k < 8; k++) line[k*32 +: 32] = 32'h11111111 * (k + 1);
    run_burst(27'h82, line, 0, 0);

    // delayed awready and toggling wready
    run_burst(27'($urandom), rand_line(), 2, 0);

    // one error response then success: full replay
    run_burst(27'h1234, rand_line(), 0, 1);

    // randomized slave timing and error counts
    for (int i = 0; i < 6; i++) begin
      run_burst(27'($urandom), rand_line(), 1, int'($urandom_range(0, 2)));
    end

    // reset during beat 4
    line = rand_line();
    addr = 27'($urandom);
    @(posedge clk); #1;
    a_write_valid = 1'b1; a_write_addr = addr; a_write_wdata = line;
    a_awready = 1'b1; a_wready = 1'b1; a_bvalid = 1'b0;
    @(posedge clk); #1;
    a_write_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("beat4_valid", a_wvalid, 1);
    check("beat4_data", a_wdata, line[3*32 +: 32]);
    @(posedge clk); #1;
    reset = 1'b1; a_awready = 1'b0; a_wready = 1'b0;
    @(negedge clk);
    check("abort_idle", {a_write_ready, a_awvalid, a_wvalid, a_bready}, 4'b1000);
    run_burst(27'($urandom), rand_line(), 0, 0);

    // single-beat instance: 0xDEADBEEF to byte address 0x100
    @(posedge clk); #1;
    b_write_valid = 1'b1; b_write_addr = 30'h40; b_write_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    b_write_valid = 1'b0;
    @(negedge clk);
    check("b_awvalid", b_awvalid, 1);
    check("b_awaddr", b_awaddr, 32'h100);
    check("b_awlen_burst_size", {b_awlen, b_awburst, b_awsize}, {8'd0, 2'b00, 3'd2});
    check("b_ready_low", b_write_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("b_wbeat", {b_wvalid, b_wlast, b_wdata}, {1'b1, 1'b1, 32'hDEADBEEF});
    @(posedge clk);
    @(negedge clk);
    check("b_bready", {b_bready, b_wvalid}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    check("b_ready_after_b", b_write_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
